reset_sequencer: RTL and testbench

Parametrised power-on and runtime reset sequencer for the FPGA top level. Holds a vector of reset outputs asserted for a programmable power-on time, waits for clock lock, then releases channels one at a time in ascending index order with a fixed stagger. Re-asserts every channel on loss of lock or on a filtered soft reset request, and then reruns the release sequence. It replaces the single-output fixed-delay reset generator and drives all downstream reset domains that run on `sys_clk`.

---
 rtl/reset_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Power-on and runtime reset sequencer for the sys_clk domain. Holds every
// reset output asserted, waits for clock lock, then releases the channels
// one by one (bit 0 first) with a fixed stagger. A lock loss or a filtered
// soft request re-asserts every channel and reruns the release sequence.
`timescale 1ns/1ps

module reset_sequencer #(
    parameter int NumChannels     = 4,
    parameter int PowerOnCycles   = 100,
    parameter int StretchCycles   = 16,
    parameter int StageCycles     = 8,
    parameter int ReqFilterCycles = 4
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   locked,
    input  logic                   soft_req,
    output logic [NumChannels-1:0] reset_out,
    output logic                   ready
);

    // Counter sized for the longest interval it ever has to cover.
    localparam int MaxHold = (PowerOnCycles > StretchCycles) ? PowerOnCycles : StretchCycles;
    localparam int MaxCyc  = (MaxHold > StageCycles) ? MaxHold : StageCycles;
    localparam int CntW    = $clog2(MaxCyc + 1);
    localparam int FiltW   = $clog2(ReqFilterCycles + 1);
    localparam int StageW  = (NumChannels > 1) ? $clog2(NumChannels) : 1;

    // Power-on hold starts from the cycle after reset releases, so the
    // counter must reach the full count. A runtime re-trigger edge already
    // puts the block in HOLD, so that edge counts as the first stretch cycle.
    localparam logic [CntW-1:0]   PonLast   = CntW'(PowerOnCycles);
    localparam logic [CntW-1:0]   StrLast   = CntW'(StretchCycles - 1);
    localparam logic [CntW-1:0]   StageLast = CntW'(StageCycles - 1);
    localparam logic [CntW-1:0]   CntOne    = CntW'(1);
    localparam logic [FiltW-1:0]  FiltLast  = FiltW'(ReqFilterCycles - 1);
    localparam logic [FiltW-1:0]  FiltSat   = FiltW'(ReqFilterCycles);
    localparam logic [FiltW-1:0]  FiltOne   = FiltW'(1);
    localparam logic [StageW-1:0] ChanLast  = StageW'(NumChannels - 1);
    localparam logic [StageW-1:0] StageOne  = StageW'(1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_WAIT_LOCK,
        ST_RELEASE,
        ST_RUN
    } state_t;

    // Initial values match the reset values so configuration and reset agree.
    state_t                  r_state   = ST_HOLD;
    logic                    r_stretch = 1'b0;   // 0: power-on hold, 1: stretch hold
    logic [CntW-1:0]         r_cnt     = '0;
    logic [FiltW-1:0]        r_filt    = '0;
    logic [StageW-1:0]       r_stage   = '0;
    logic [NumChannels-1:0]  r_rst_out = '1;
    logic                    r_ready   = 1'b0;

    state_t                  w_state_nxt;
    logic                    w_stretch_nxt;
    logic [CntW-1:0]         w_cnt_nxt;
    logic [FiltW-1:0]        w_filt_nxt;
    logic [StageW-1:0]       w_stage_nxt;
    logic [NumChannels-1:0]  w_rst_out_nxt;
    logic                    w_ready_nxt;

    logic                    w_soft_trig;
    logic                    w_lock_loss;
    logic                    w_retrig;
    logic [CntW-1:0]         w_hold_last;

    // Soft request filter: count consecutive high samples, saturating so a
    // held request fires exactly once.
    always_comb begin
        w_filt_nxt  = r_filt;
        w_soft_trig = 1'b0;
        if (!soft_req) begin
            w_filt_nxt = '0;
        end else begin
            if (r_filt != FiltSat) begin
                w_filt_nxt = r_filt + FiltOne;
            end
            w_soft_trig = (r_filt == FiltLast);
        end
    end

    // Re-trigger decode. Lock loss and soft trigger share one action, so a
    // coincident pair yields a single stretch.
    always_comb begin
        w_lock_loss = !locked && ((r_state == ST_RELEASE) || (r_state == ST_RUN));
        w_retrig    = w_lock_loss || (w_soft_trig && (r_state != ST_HOLD));
        w_hold_last = r_stretch ? StrLast : PonLast;
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_stretch_nxt = r_stretch;
        w_cnt_nxt     = r_cnt;
        w_stage_nxt   = r_stage;
        w_rst_out_nxt = r_rst_out;
        w_ready_nxt   = r_ready;

        if (w_retrig) begin
            w_state_nxt   = ST_HOLD;
            w_stretch_nxt = 1'b1;
            w_cnt_nxt     = '0;
            w_stage_nxt   = '0;
            w_rst_out_nxt = '1;
            w_ready_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    w_rst_out_nxt = '1;
                    w_ready_nxt   = 1'b0;
                    if (r_stretch && soft_req) begin
                        // Stretch is timed from request deassertion.
                        w_cnt_nxt = '0;
                    end else if (r_cnt == w_hold_last) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CntOne;
                    end
                end

                ST_WAIT_LOCK: begin
                    w_rst_out_nxt = '1;
                    w_ready_nxt   = 1'b0;
                    if (locked) begin
                        w_state_nxt = ST_RELEASE;
                        w_cnt_nxt   = '0;
                        w_stage_nxt = '0;
                    end
                end

                ST_RELEASE: begin
                    if (r_cnt == StageLast) begin
                        w_cnt_nxt = '0;
                        for (int i = 0; i < NumChannels; i++) begin
                            if (r_stage == StageW'(i)) begin
                                w_rst_out_nxt[i] = 1'b0;
                            end
                        end
                        if (r_stage == ChanLast) begin
                            w_state_nxt = ST_RUN;
                            w_ready_nxt = 1'b1;
                        end else begin
                            w_stage_nxt = r_stage + StageOne;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CntOne;
                    end
                end

                ST_RUN: begin
                    w_rst_out_nxt = '0;
                    w_ready_nxt   = 1'b1;
                end

                default: begin
                    w_state_nxt   = ST_HOLD;
                    w_stretch_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                    w_stage_nxt   = '0;
                    w_rst_out_nxt = '1;
                    w_ready_nxt   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset returns to power-on hold.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state   <= ST_HOLD;
            r_stretch <= 1'b0;
            r_cnt     <= '0;
            r_filt    <= '0;
            r_stage   <= '0;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_stretch <= w_stretch_nxt;
            r_cnt     <= w_cnt_nxt;
            r_filt    <= w_filt_nxt;
            r_stage   <= w_stage_nxt;
            r_rst_out <= w_rst_out_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign reset_out = r_rst_out;
    assign ready     = r_ready;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer with P=10, Str=6, S=4, N=3, F=4.
`timescale 1ns/1ps

module tb_reset_sequencer;

    localparam int N   = 3;
    localparam int P   = 10;
    localparam int STR = 6;
    localparam int S   = 4;
    localparam int F   = 4;

    logic         sys_clk;
    logic         reset;
    logic         locked;
    logic         soft_req;
    logic [N-1:0] reset_out;
    logic         ready;

    int total = 0;
    int bad   = 0;

    reset_sequencer #(
        .NumChannels    (N),
        .PowerOnCycles  (P),
        .StretchCycles  (STR),
        .StageCycles    (S),
        .ReqFilterCycles(F)
    ) dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .locked   (locked),
        .soft_req (soft_req),
        .reset_out(reset_out),
        .ready    (ready)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // One segment: hold these inputs for n edges; after every edge the
    // outputs must equal {rdy, out}.
    typedef struct {
        logic         rst;
        logic         lck;
        logic         req;
        int           n;
        logic [N-1:0] out;
        logic         rdy;
        string        name;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic lck, input logic req,
                                input int n, input logic [N-1:0] out, input logic rdy,
                                input string name);
        vec_t v;
        v.rst = rst; v.lck = lck; v.req = req; v.n = n;
        v.out = out; v.rdy = rdy; v.name = name;
        tbl.push_back(v);
    endfunction

    // Standard re-release after a re-trigger edge TR with soft_req low:
    // bit i falls at TR + STR + 1 + S*(i+1).
    function automatic void add_rerelease(input string tag);
        add(0, 1, 0, STR + S, 3'b111, 0, {tag, "_hold"});
        add(0, 1, 0, S,       3'b110, 0, {tag, "_b0"});
        add(0, 1, 0, S,       3'b100, 0, {tag, "_b1"});
        add(0, 1, 0, 3,       3'b000, 1, {tag, "_run"});
    endfunction

    // Power-on release from T0 with lock high: bits fall at T0+15/19/23.
    function automatic void add_poweron(input string tag);
        add(0, 1, 0, P + 1 + S, 3'b111, 0, {tag, "_hold"});
        add(0, 1, 0, S,         3'b110, 0, {tag, "_b0"});
        add(0, 1, 0, S,         3'b100, 0, {tag, "_b1"});
        add(0, 1, 0, 4,         3'b000, 1, {tag, "_run"});
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;

        reset    = 1'b1;
        locked   = 1'b1;
        soft_req = 1'b0;

        // Reset state and power-on sequence.
        add(1, 1, 0, 3, 3'b111, 0, "reset_state");
        add_poweron("pon");
        // One-cycle lock glitch in RUN.
        add(0, 0, 0, 1, 3'b111, 0, "glitch");
        add_rerelease("glitch");
        // Three-sample soft pulse: no effect.
        add(0, 1, 1, 3, 3'b000, 1, "req3");
        add(0, 1, 0, 3, 3'b000, 1, "req3_after");
        // Four-sample soft pulse fires on the 4th sample.
        add(0, 1, 1, 3, 3'b000, 1, "req4_pre");
        add(0, 1, 1, 1, 3'b111, 0, "req4_fire");
        add_rerelease("req4");
        // Request held 20 samples: HOLD until release plus the stretch.
        add(0, 1, 1, 3,  3'b000, 1, "held_pre");
        add(0, 1, 1, 17, 3'b111, 0, "held_hi");
        add_rerelease("held");
        // Lock loss and soft trigger on the same edge: one stretch.
        add(0, 1, 1, 3, 3'b000, 1, "both_pre");
        add(0, 0, 1, 1, 3'b111, 0, "both_fire");
        add(0, 1, 0, STR + S, 3'b111, 0, "both_hold");
        add(0, 1, 0, 2,       3'b110, 0, "both_b0");
        // Reset mid-release after bit 0 fell: full power-on rerun.
        add(1, 1, 0, 1, 3'b111, 0, "rst_mid");
        add_poweron("rerun");
        // Late lock: locked first sampled high at T0+31.
        add(1, 0, 0, 2,  3'b111, 0, "late_rst");
        add(0, 0, 0, 31, 3'b111, 0, "late_wait");
        add(0, 1, 0, S,  3'b111, 0, "late_rel");
        add(0, 1, 0, S,  3'b110, 0, "late_b0");
        add(0, 1, 0, S,  3'b100, 0, "late_b1");
        add(0, 1, 0, 3,  3'b000, 1, "late_run");

        foreach (tbl[i]) begin
            reset    = tbl[i].rst;
            locked   = tbl[i].lck;
            soft_req = tbl[i].req;
            for (int k = 0; k < tbl[i].n; k++) begin
                tick();
                chk($sformatf("%s[%0d]", tbl[i].name, k),
                    {28'd0, ready, reset_out}, {28'd0, tbl[i].rdy, tbl[i].out});
            end
        end

        // Request held through the whole power-on sequence: the filter
        // saturates while in HOLD and must never fire afterwards.
        reset = 1'b1; locked = 1'b1; soft_req = 1'b0;
        tick(); tick();
        chk("sat_reset", {28'd0, ready, reset_out}, 32'h7);
        reset = 1'b0; soft_req = 1'b1;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!ready && cnt < 60);
        chk("sat_ready_edge", cnt, P + 1 + N * S + 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("sat_hold[%0d]", k), {28'd0, ready, reset_out}, 32'h8);
        end
        soft_req = 1'b0;

        // Soft trigger while in WAIT_LOCK restarts the stretch.
        reset = 1'b1; locked = 1'b0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        soft_req = 1'b1;
        for (int k = 0; k < F; k++) begin
            tick();
            chk($sformatf("wl_req[%0d]", k), {28'd0, ready, reset_out}, 32'h7);
        end
        soft_req = 1'b0; locked = 1'b1;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (reset_out[0] && cnt < 60);
        chk("wl_b0_edge", cnt, STR + 1 + S);
        chk("wl_b0_out", {28'd0, ready, reset_out}, 32'h6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
